lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 33 +++
 rtl/lsu_ctrl.sv | 134 +++++++++++++
 tb/tb_lsu_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and data-memory bus of the load/store unit.
// A request is taken on a rising edge where req_valid && req_ready; a memory access completes on an edge where mem_req && mem_ack.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: checks alignment, drives one data-memory access
// with byte lanes, aligns/extends load data and aborts accesses that never get acked.
module lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  state_t         state;
  logic [CW-1:0]  tmo_cnt;
  logic [2:0]     r_funct3;
  logic [1:0]     r_lane;

  logic           illegal;
  logic [3:0]     be_next;
  logic [31:0]    wdata_next;
  logic [31:0]    shifted;
  logic [31:0]    load_data;

  always_comb begin
    illegal = 1'b0;
    if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 || bus.req_funct3 == 3'b111)
      illegal = 1'b1;
    if (bus.req_we && bus.req_funct3[2])
      illegal = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
      illegal = 1'b1;
    if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
      illegal = 1'b1;
  end

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << bus.req_addr[1:0];
        wdata_next = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << bus.req_addr[1:0];
        wdata_next = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  always_comb begin
    shifted   = bus.mem_rdata >> {r_lane, 3'b000};
    load_data = shifted;
    case (r_funct3[1:0])
      2'b00: load_data = r_funct3[2] ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = r_funct3[2] ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE) || bus.req_valid;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      r_funct3       <= 3'd0;
      r_lane         <= 2'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.mem_req    <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.mem_be     <= 4'd0;
      bus.mem_wdata  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_funct3 <= bus.req_funct3;
            r_lane   <= bus.req_addr[1:0];
            if (illegal) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= 32'd0;
            end else begin
              state         <= ISSUE;
              tmo_cnt       <= '0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= bus.req_we;
              bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
              bus.mem_be    <= be_next;
              bus.mem_wdata <= wdata_next;
            end
          end
        end
        ISSUE: begin
          // An ack on the last allowed cycle still wins over the timeout.
          if (bus.mem_ack) begin
            state          <= RESP;
            bus.mem_req    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= bus.mem_we ? 32'd0 : load_data;
          end else if (tmo_cnt == TMO_LAST) begin
            state          <= RESP;
            bus.mem_req    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
            bus.resp_rdata <= 32'd0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        RESP: begin
          state          <= IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed table-driven bench for lsu_ctrl plus hand sequences for reset,
// stray acks and requests arriving while busy.
module tb_lsu_ctrl;
  localparam int TMO = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         total;
  int         bad;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;   // -1: never ack
    logic        ill;
    logic        poke;     // raise a stray request during ISSUE
    logic [3:0]  be;
    logic [31:0] maddr;
    logic        chk_wd;
    logic [31:0] mwdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int wait_n,
                              input logic ill, input logic poke, input logic [3:0] be,
                              input logic [31:0] maddr, input logic chk_wd, input logic [31:0] mwdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.wait_n = wait_n; v.ill = ill; v.poke = poke; v.be = be; v.maddr = maddr;
    v.chk_wd = chk_wd; v.mwdata = mwdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, input string tag);
    int mreq_cnt;
    int resp_cyc;
    int unstable;
    int exp_cyc;
    int exp_mreq;
    mreq_cnt = 0;
    resp_cyc = 0;
    unstable = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.mem_rdata  = v.rdata;
    bus.mem_ack    = 1'b0;
    #1;
    chk({tag, ".busy_idle_req"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, ".ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        resp_cyc = c;
        break;
      end
      if (bus.mem_req) begin
        mreq_cnt++;
        if (mreq_cnt == 1) begin
          chk({tag, ".mem_be"}, {28'd0, bus.mem_be}, {28'd0, v.be});
          chk({tag, ".mem_addr"}, bus.mem_addr, v.maddr);
          chk({tag, ".mem_we"}, {31'd0, bus.mem_we}, {31'd0, v.we});
          if (v.chk_wd) chk({tag, ".mem_wdata"}, bus.mem_wdata, v.mwdata);
        end else if (bus.mem_be !== v.be || bus.mem_addr !== v.maddr || bus.mem_we !== v.we ||
                     (v.chk_wd && bus.mem_wdata !== v.mwdata)) begin
          unstable++;
        end
      end
      bus.mem_ack = bus.mem_req && (v.wait_n >= 0) && (mreq_cnt == v.wait_n + 1);
      if (v.poke) begin
        if (mreq_cnt == 1) begin
          bus.req_valid  = 1'b1;
          bus.req_funct3 = 3'b111;
          #1;
          chk({tag, ".ready_busy"}, {31'd0, bus.req_ready}, 32'd0);
          chk({tag, ".busy_issue"}, {31'd0, bus.busy}, 32'd1);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    bus.mem_ack   = 1'b0;
    bus.req_valid = 1'b0;
    exp_cyc  = v.ill ? 1 : (v.wait_n < 0 ? TMO + 1 : v.wait_n + 2);
    exp_mreq = v.ill ? 0 : (v.wait_n < 0 ? TMO : v.wait_n + 1);
    chk({tag, ".resp_latency"}, resp_cyc, exp_cyc);
    chk({tag, ".mem_req_cycles"}, mreq_cnt, exp_mreq);
    chk({tag, ".mem_stable"}, unstable, 0);
    chk({tag, ".resp_err"}, {31'd0, bus.resp_err}, {31'd0, v.exp_err});
    chk({tag, ".resp_rdata"}, bus.resp_rdata, v.exp_rdata);
    @(negedge clk);
    chk({tag, ".resp_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, ".rdata_hold"}, bus.resp_rdata, v.exp_rdata);
    chk({tag, ".err_hold"}, {31'd0, bus.resp_err}, {31'd0, v.exp_err});
    @(negedge clk);
    chk({tag, ".no_recapture"}, {30'd0, dbg_state, bus.mem_req, bus.resp_valid}, 32'd0);
  endtask

  vec_t vecs[15];

  initial begin
    total = 0;
    bad   = 0;
    //               we    f3      addr          wdata         rdata         wait ill  poke be       maddr         cwd  mwdata        rdata         err
    vecs[0]  = mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 0, 1'b0, 1'b0, 4'b1000, 32'h0000_0100, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0);
    vecs[1]  = mk(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h9234_5678, 0, 1'b0, 1'b0, 4'b1100, 32'h0000_0100, 1'b0, 32'h0,        32'h0000_9234, 1'b0);
    vecs[2]  = mk(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF, 32'h1111_1111, 3, 1'b0, 1'b0, 4'b1100, 32'h0000_0200, 1'b1, 32'hBEEF_BEEF, 32'h0,        1'b0);
    vecs[3]  = mk(1'b0, 3'b010, 32'h0000_0301, 32'h0,        32'h0,         0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,        32'h0,        1'b1);
    vecs[4]  = mk(1'b0, 3'b011, 32'h0000_0300, 32'h0,        32'h0,         0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,        32'h0,        1'b1);
    vecs[5]  = mk(1'b0, 3'b010, 32'h0000_0500, 32'h0,        32'hFFFF_FFFF, -1, 1'b0, 1'b0, 4'b1111, 32'h0000_0500, 1'b0, 32'h0,       32'h0,        1'b1);
    vecs[6]  = mk(1'b0, 3'b001, 32'h0000_0106, 32'h0,        32'hF00D_1234, 1, 1'b0, 1'b0, 4'b1100, 32'h0000_0104, 1'b0, 32'h0,        32'hFFFF_F00D, 1'b0);
    vecs[7]  = mk(1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h1234_5678, 0, 1'b0, 1'b0, 4'b0010, 32'h0000_0100, 1'b0, 32'h0,        32'h0000_0056, 1'b0);
    vecs[8]  = mk(1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'hCAFE_F00D, 2, 1'b0, 1'b1, 4'b1111, 32'h0000_0010, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b0);
    vecs[9]  = mk(1'b1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0,       0, 1'b0, 1'b0, 4'b1000, 32'h0000_0000, 1'b1, 32'hA5A5_A5A5, 32'h0,        1'b0);
    vecs[10] = mk(1'b1, 3'b010, 32'h0000_0400, 32'h1234_5678, 32'hFFFF_0000, 0, 1'b0, 1'b0, 4'b1111, 32'h0000_0400, 1'b1, 32'h1234_5678, 32'h0,     1'b0);
    vecs[11] = mk(1'b1, 3'b001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0,       0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,        32'h0,        1'b1);
    vecs[12] = mk(1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,        32'h0,        1'b1);
    vecs[13] = mk(1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'hFFFF_FF7F, 0, 1'b0, 1'b0, 4'b0001, 32'h0000_0000, 1'b0, 32'h0,        32'h0000_007F, 1'b0);
    vecs[14] = mk(1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'h0,         0, 1'b1, 1'b0, 4'b0000, 32'h0,         1'b0, 32'h0,        32'h0,        1'b1);

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.resp", {bus.resp_valid, bus.resp_err, 30'd0}, 32'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst.mem_ctl", {bus.mem_req, bus.mem_we, 26'd0, bus.mem_be}, 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst.state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // Stray acks while idle must not start or complete anything.
    for (int i = 0; i < 3; i++) begin
      bus.mem_ack = 1'b1;
      @(negedge clk);
      chk($sformatf("idle_ack%0d", i), {29'd0, dbg_state, bus.resp_valid}, 32'd0);
    end
    bus.mem_ack = 1'b0;

    for (int i = 0; i < 15; i++)
      do_access(vecs[i], $sformatf("v%0d", i));

    // Reset landing in the second ISSUE cycle aborts silently.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0600;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rstiss.mem_req_c1", {31'd0, bus.mem_req}, 32'd1);
    @(negedge clk);
    chk("rstiss.mem_req_c2", {31'd0, bus.mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstiss.mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rstiss.req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstiss.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.resp_valid || bus.mem_req) seen++;
      end
      chk("rstiss.quiet", seen, 0);
    end
    do_access(vecs[10], "post_rst_sw");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
